uart_rx_deserializer: RTL and testbench

Front-end serial receiver of the UART RX path. It oversamples the asynchronous `rxd` line at 16x baud, detects and validates the start bit, and shifts in 8 data bits LSB-first. It checks the stop bit (and, optionally, a parity bit), then presents the byte on `rx_data` with the `rx_rdy` handshake consumed by the RX main FSM directly downstream.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_deserializer.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive types and constants.
// Latency: none (definitions only).
// Backpressure: none.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Conditions the asynchronous rxd line: 2-flop synchronizer, then 3-tap majority on sample_tick.
// Latency: 2 clk plus up to 2 sample_tick periods to rxd_f.
// Backpressure: none; free-running.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic rxd,
  output logic rxd_f
);

  logic [1:0] sync;
  logic [2:0] taps;

  // Idle line is high, so everything resets to 1 to avoid a phantom start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      taps <= 3'b111;
    end else begin
      sync <= {sync[0], rxd};
      if (sample_tick) begin
        taps <= {taps[1:0], sync[1]};
      end
    end
  end

  assign rxd_f = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART RX front end: 16x oversampled start detect, LSB-first shift, stop check; optional even parity via UART_RX_PARITY_EN.
// Latency: rx_rdy rises 1 clk after the mid-stop-bit sample_tick (9.5 / 10.5 bits after the start edge plus filter delay).
// Backpressure: none; rx_data is held until the next frame completes, downstream must consume within 0.5 bit of rx_rdy rising.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_rdy,
  output logic              rx_active,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int              TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]   BIT_END   = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic [TW-1:0]     tick_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              rxd_f;
  logic              cnt_clr, start_ok, shift_en, stop_en;

  uart_rx_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rxd         (rxd),
    .rxd_f       (rxd_f)
  );

`ifdef UART_RX_PARITY_EN
  logic par_en;
  logic parity_err_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Counter phase is re-centred at mid start bit, so every later sample lands on tick_cnt == BIT_END.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    stop_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    if (sample_tick) begin
      case (state)
        IDLE: begin
          if (!rxd_f) begin
            cnt_clr   = 1'b1;
            state_nxt = START;
          end
        end
        START: begin
          if (tick_cnt == MID_START) begin
            if (rxd_f) begin
              state_nxt = IDLE;
            end else begin
              cnt_clr   = 1'b1;
              start_ok  = 1'b1;
              state_nxt = DATA;
            end
          end
        end
        DATA: begin
          if (tick_cnt == BIT_END) begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick_cnt == BIT_END) begin
            par_en    = 1'b1;
            state_nxt = STOP;
          end
`else
          state_nxt = IDLE;
`endif
        end
        STOP: begin
          if (tick_cnt == BIT_END) begin
            stop_en   = 1'b1;
            state_nxt = rxd_f ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rxd_f) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      if (sample_tick) begin
        tick_cnt <= cnt_clr ? '0 : tick_cnt + 1'b1;
      end
      if (start_ok) begin
        bit_cnt <= '0;
        rx_rdy  <= 1'b0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shreg <= {rxd_f, shreg[DATA_W-1:1]};
      end
      if (stop_en) begin
        rx_data   <= shreg;
        frame_err <= ~rxd_f;
        rx_rdy    <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_next <= 1'b0;
      parity_err      <= 1'b0;
    end else begin
      if (par_en)  parity_err_next <= rxd_f ^ (^shreg);
      if (stop_en) parity_err      <= parity_err_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign rx_active = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frame-level model queue checked on every cycle plus literal pins.
module tb_uart_rx_deserializer;

  localparam int BIT = 32;  // clk per bit: sample_tick every 2 clk, 16 ticks per bit
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT_NOM = (PAR_EN ? 21 : 19) * (BIT / 2);
  localparam int LOW_MIN = 9 * BIT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_rdy, rx_active, frame_err, parity_err;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         start;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rises = 0;
  int   fall_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;
  logic       prev_rdy = 1'b1;

  uart_rx_deserializer dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .rx_active   (rx_active),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      sample_tick = ~sample_tick;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // What a receiver must report for a frame, straight from its bits.
  function automatic exp_t model(input logic [7:0] d, input bit stop_b, input bit par_b, input int st);
    exp_t e;
    e.data  = d;
    e.ferr  = ~stop_b;
    e.perr  = PAR_EN ? (par_b ^ (^d)) : 1'b0;
    e.start = st;
    return e;
  endfunction

  // Called on a negedge; returns on a negedge at the end of the stop bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_b,
                            input bit expect_it, input int rst_bit);
    rxd = 1'b0;
    if (expect_it) q.push_back(model(d, stop_b, par_b, cyc));
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == rst_bit) begin
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (BIT / 2 - 1) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    if (PAR_EN) begin
      rxd = par_b;
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_b;
    repeat (BIT) @(negedge clk);
  endtask

  // Per-cycle compare against the frame queue.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_rdy", rx_rdy, 1'b1);
      chk("rst_rx_active", rx_active, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_parity_err", parity_err, 1'b0);
      q.delete();
      last_data = 8'h00;
      last_ferr = 1'b0;
      last_perr = 1'b0;
      prev_rdy  = 1'b1;
    end else begin
      if (!rx_rdy && prev_rdy) fall_cyc = cyc;
      if (rx_rdy && !prev_rdy) begin
        exp_t e;
        rises++;
        chk_range("rdy_low_len", cyc - fall_cyc, LOW_MIN, LOW_MIN + BIT);
        if (q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("frame_data", rx_data, e.data);
          chk("frame_ferr", frame_err, e.ferr);
          chk("frame_perr", parity_err, e.perr);
          chk_range("frame_latency", cyc - e.start, LAT_NOM, LAT_NOM + 16);
          last_data = e.data;
          last_ferr = e.ferr;
          last_perr = e.perr;
        end
      end else begin
        chk("hold_data", rx_data, last_data);
        chk("hold_ferr", frame_err, last_ferr);
        chk("hold_perr", parity_err, last_perr);
      end
      if (!rx_rdy) chk("active_while_busy", rx_active, 1'b1);
      prev_rdy = rx_rdy;
    end
  end

  initial begin
    int exp_rises;
    exp_rises = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    // Nominal 0xA5 (even parity bit 0)
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
    exp_rises++;
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr", frame_err, 1'b0);
    chk("a5_perr", parity_err, 1'b0);
    chk("a5_active", rx_active, 1'b0);
    chk("a5_rises", rises, exp_rises);
    repeat (BIT) @(negedge clk);

    // Glitch: 4 sample_ticks low
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_rdy", rx_rdy, 1'b1);
    chk("glitch_active", rx_active, 1'b0);
    chk("glitch_data", rx_data, 8'hA5);
    chk("glitch_rises", rises, exp_rises);

    // Break: 0x3C with low stop, line held low 3 bit times
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    exp_rises++;
    repeat (2 * BIT) @(negedge clk);
    chk("brk_data", rx_data, 8'h3C);
    chk("brk_ferr", frame_err, 1'b1);
    chk("brk_waiting", rx_active, 1'b1);
    chk("brk_rdy", rx_rdy, 1'b1);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("brk_released", rx_active, 1'b0);
    chk("brk_rises", rises, exp_rises);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, -1);
    exp_rises++;
    chk("x55_data", rx_data, 8'h55);
    chk("x55_ferr_clear", frame_err, 1'b0);
    repeat (BIT) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, -1);
    exp_rises++;
    chk("p81_bad_perr", parity_err, 1'b1);
    repeat (BIT) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, -1);
    exp_rises++;
    chk("p81_good_perr", parity_err, 1'b0);
    chk("p81_data", rx_data, 8'h81);
    repeat (BIT) @(negedge clk);
`endif

    // Reset in the middle of bit 4 of 0xF0, then 0x0F
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 4);
    chk("rst_mid_data", rx_data, 8'h00);
    chk("rst_mid_rdy", rx_rdy, 1'b1);
    chk("rst_mid_active", rx_active, 1'b0);
    repeat (BIT) @(negedge clk);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1);
    exp_rises++;
    chk("x0f_data", rx_data, 8'h0F);
    chk("x0f_ferr", frame_err, 1'b0);
    repeat (BIT) @(negedge clk);

    // Back-to-back 0x00 then 0xFF (0xFF even parity bit 0)
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, -1);
    exp_rises++;
    chk("b2b_first", rx_data, 8'h00);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, -1);
    exp_rises++;
    chk("b2b_second", rx_data, 8'hFF);
    chk("b2b_ferr", frame_err, 1'b0);
    chk("b2b_perr", parity_err, 1'b0);
    repeat (2 * BIT) @(negedge clk);

    chk("total_rises", rises, exp_rises);
    chk("frames_pending", q.size(), 0);
    chk("final_idle", rx_active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
